// File: rtl/rv_pipelined_shift_unit_pkg.sv
// rv_shift_pkg: shared types and sizing helpers for the pipelined shift unit.
//   shift_op_e      - operation encoding seen on in_op (5..7 are illegal)
//   fill_e / ctrl_t - decoded control carried down the pipeline
//   shamt_w()       - number of conditional shift steps for a datapath width
//   steps_per_stage - steps handled by each of the earlier pipeline stages
package rv_shift_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        SLL = 3'd0,
        SRL = 3'd1,
        SRA = 3'd2,
        ROL = 3'd3,
        ROR = 3'd4
    } shift_op_e;

    // What gets shifted in at the vacated end of each step.
    typedef enum logic [1:0] {
        FILL_ZERO = 2'd0,
        FILL_SIGN = 2'd1,
        FILL_ROT  = 2'd2
    } fill_e;

    typedef struct packed {
        logic       left;   // 1: shift towards MSB
        fill_e      fill;
        logic       word;   // result is sign-extended from bit 31
        logic [5:0] shamt;  // already masked to the legal range
    } ctrl_t;

    function automatic int shamt_w(input int xlen);
        return $clog2(xlen);
    endfunction

    function automatic int steps_per_stage(input int xlen, input int stages);
        return (shamt_w(xlen) + stages - 1) / stages;
    endfunction

endpackage

// File: rtl/rv_pipelined_shift_unit_if.sv
// rv_pipelined_shift_unit_if: request/result handshake bundle of the shift unit.
//   in_*  : operation offered by the issue logic (in_ready flows back)
//   out_* : result presented to the consumer (out_ready flows back)
// modport master = issuing/consuming side, modport slave = the shift unit.
interface rv_pipelined_shift_unit_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) ();
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic             in_word;
    logic             in_imm;
    logic [31:0]      in_instr;
    logic [XLEN-1:0]  in_rs1;
    logic [XLEN-1:0]  in_rs2;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_rd;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_op, in_word, in_imm, in_instr, in_rs1, in_rs2, in_tag, out_ready,
        input  in_ready, out_valid, out_rd, out_tag
    );

    modport slave (
        input  in_valid, in_op, in_word, in_imm, in_instr, in_rs1, in_rs2, in_tag, out_ready,
        output in_ready, out_valid, out_rd, out_tag
    );
endinterface

// File: rtl/rv_pipelined_shift_unit_stage.sv
// rv_shift_stage: one pipeline register preceded by STEP_CNT conditional
// shift steps (step k shifts by 2**k when shamt[k] is set).
//   clk, rst_n        - clock, synchronous active-low reset
//   flush_i           - clears valid
//   load_i            - stage may take a new payload (empty or advancing)
//   valid_i/data_i/ctrl_i/tag_i - payload from the previous stage or decode
//   valid_o/data_o/ctrl_o/tag_o - registered payload
module rv_shift_stage
    import rv_shift_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int TAG_W      = 5,
    parameter int FIRST_STEP = 0,
    parameter int STEP_CNT   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             load_i,
    input  logic             valid_i,
    input  logic [XLEN-1:0]  data_i,
    input  ctrl_t            ctrl_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             valid_o,
    output logic [XLEN-1:0]  data_o,
    output ctrl_t            ctrl_o,
    output logic [TAG_W-1:0] tag_o
);
    logic [XLEN-1:0]  net [0:STEP_CNT];
    logic [XLEN-1:0]  data_d;
    logic             valid_q;
    logic [XLEN-1:0]  data_q;
    ctrl_t            ctrl_q;
    logic [TAG_W-1:0] tag_q;

    assign net[0] = data_i;

    genvar gi;
    generate
        for (gi = 0; gi < STEP_CNT; gi++) begin : g_step
            localparam int AMT = 1 << (FIRST_STEP + gi);
            logic [AMT-1:0]  lfill;
            logic [AMT-1:0]  rfill;
            logic [XLEN-1:0] shifted;

            // Rotates reuse the shifter: the bits falling off one end are
            // fed back in at the other.
            always_comb begin
                lfill = (ctrl_i.fill == FILL_ROT) ? net[gi][XLEN-1 -: AMT] : '0;
                if (ctrl_i.fill == FILL_ROT) begin
                    rfill = net[gi][AMT-1:0];
                end else if (ctrl_i.fill == FILL_SIGN) begin
                    rfill = {AMT{net[gi][XLEN-1]}};
                end else begin
                    rfill = '0;
                end
                if (!ctrl_i.shamt[FIRST_STEP+gi]) begin
                    shifted = net[gi];
                end else if (ctrl_i.left) begin
                    shifted = {net[gi][XLEN-1-AMT:0], lfill};
                end else begin
                    shifted = {rfill, net[gi][XLEN-1:AMT]};
                end
            end

            assign net[gi+1] = shifted;
        end
    endgenerate

    assign data_d = net[STEP_CNT];

    // Payload only moves with a live operation so an idle output holds its
    // last result; flush also leaves the payload untouched.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            ctrl_q  <= '0;
            tag_q   <= '0;
        end else begin
            if (flush_i) begin
                valid_q <= 1'b0;
            end else if (load_i) begin
                valid_q <= valid_i;
            end
            if (load_i && valid_i && !flush_i) begin
                data_q <= data_d;
                ctrl_q <= ctrl_i;
                tag_q  <= tag_i;
            end
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign ctrl_o  = ctrl_q;
    assign tag_o   = tag_q;

endmodule

// File: rtl/rv_pipelined_shift_unit.sv
// rv_pipelined_shift_unit: STAGES-deep shift/rotate unit with W forms,
// valid/ready back-pressure, flush and tag pass-through.
//   clk   - rising-edge clock
//   rst_n - synchronous active-low reset
//   flush - kills every in-flight operation
//   bus   - slave side of rv_pipelined_shift_unit_if (in_* request, out_* result)
module rv_pipelined_shift_unit
    import rv_shift_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int STAGES = 2,
    parameter int TAG_W  = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic flush,
    rv_pipelined_shift_unit_if.slave bus
);
    localparam int SW  = shamt_w(XLEN);
    localparam int SPS = steps_per_stage(XLEN, STAGES);

    logic [XLEN-1:0]  dec_data;
    ctrl_t            dec_ctrl;
    logic             dec_word;
    logic [5:0]       shamt_raw;
    logic             accept;
    logic [STAGES-1:0] adv;
    logic [STAGES-1:0] load;
    logic [STAGES-1:0] st_valid;
    logic [XLEN-1:0]  st_data [0:STAGES-1];
    ctrl_t            st_ctrl [0:STAGES-1];
    logic [TAG_W-1:0] st_tag  [0:STAGES-1];
    logic             unused_bits;

    // Decode. W forms pre-condition the operand so the full-width network
    // yields the right low word: sign-extend for SRA, duplicate the word
    // into every 32-bit lane for rotates, zero-extend otherwise.
    always_comb begin
        shamt_raw      = bus.in_imm ? bus.in_instr[25:20] : bus.in_rs2[5:0];
        dec_word       = (XLEN == 64) && bus.in_word;
        dec_ctrl       = '0;
        dec_ctrl.word  = dec_word;
        dec_ctrl.shamt = shamt_raw & ((dec_word || XLEN == 32) ? 6'h1F : 6'h3F);
        dec_data       = dec_word ? XLEN'(bus.in_rs1[31:0]) : bus.in_rs1;
        case (shift_op_e'(bus.in_op))
            SLL: begin
                dec_ctrl.left = 1'b1;
                dec_ctrl.fill = FILL_ZERO;
            end
            SRL: begin
                dec_ctrl.fill = FILL_ZERO;
            end
            SRA: begin
                dec_ctrl.fill = FILL_SIGN;
                if (dec_word) dec_data = XLEN'(signed'(bus.in_rs1[31:0]));
            end
            ROL: begin
                dec_ctrl.left = 1'b1;
                dec_ctrl.fill = FILL_ROT;
                if (dec_word) dec_data = {(XLEN/32){bus.in_rs1[31:0]}};
            end
            ROR: begin
                dec_ctrl.fill = FILL_ROT;
                if (dec_word) dec_data = {(XLEN/32){bus.in_rs1[31:0]}};
            end
            default: begin
                // Illegal op: shifting zero gives zero whatever the amount.
                dec_data = '0;
            end
        endcase
    end

    // Back-pressure chain: stage i may move when its successor is empty or
    // moving itself; the last stage moves when the consumer takes it.
    always_comb begin
        adv = '0;
        adv[STAGES-1] = bus.out_ready;
        for (int i = STAGES - 2; i >= 0; i--) begin
            adv[i] = !st_valid[i+1] || adv[i+1];
        end
        load = ~st_valid | adv;
    end

    assign bus.in_ready = load[0] && !flush;
    assign accept       = bus.in_valid && bus.in_ready;

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            localparam int REM = SW - gi * SPS;
            localparam int CNT = (REM > SPS) ? SPS : ((REM > 0) ? REM : 0);
            logic             v_in;
            logic [XLEN-1:0]  d_in;
            ctrl_t            c_in;
            logic [TAG_W-1:0] t_in;

            if (gi == 0) begin : g_head
                assign v_in = accept;
                assign d_in = dec_data;
                assign c_in = dec_ctrl;
                assign t_in = bus.in_tag;
            end else begin : g_body
                assign v_in = st_valid[gi-1];
                assign d_in = st_data[gi-1];
                assign c_in = st_ctrl[gi-1];
                assign t_in = st_tag[gi-1];
            end

            rv_shift_stage #(
                .XLEN       (XLEN),
                .TAG_W      (TAG_W),
                .FIRST_STEP (gi * SPS),
                .STEP_CNT   (CNT)
            ) u_stage (
                .clk     (clk),
                .rst_n   (rst_n),
                .flush_i (flush),
                .load_i  (load[gi]),
                .valid_i (v_in),
                .data_i  (d_in),
                .ctrl_i  (c_in),
                .tag_i   (t_in),
                .valid_o (st_valid[gi]),
                .data_o  (st_data[gi]),
                .ctrl_o  (st_ctrl[gi]),
                .tag_o   (st_tag[gi])
            );
        end
    endgenerate

    assign bus.out_valid = st_valid[STAGES-1];
    assign bus.out_tag   = st_tag[STAGES-1];
    assign bus.out_rd    = st_ctrl[STAGES-1].word ? XLEN'(signed'(st_data[STAGES-1][31:0]))
                                                  : st_data[STAGES-1];

    // Instruction/operand bits outside the shamt field are don't-care.
    assign unused_bits = ^{bus.in_instr[31:26], bus.in_instr[19:0], bus.in_rs2[XLEN-1:6],
                           st_ctrl[STAGES-1].left, st_ctrl[STAGES-1].fill,
                           st_ctrl[STAGES-1].shamt};

endmodule

// File: tb/tb_rv_pipelined_shift_unit.sv
module tb_rv_pipelined_shift_unit;
    import rv_shift_pkg::*;

    typedef struct packed {
        logic [4:0]  tag;
        logic [63:0] rd;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic flush;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t q32[$];
    exp_t q64[$];

    always #5 clk = ~clk;

    rv_pipelined_shift_unit_if #(.XLEN(32), .TAG_W(5)) if32 ();
    rv_pipelined_shift_unit_if #(.XLEN(64), .TAG_W(5)) if64 ();

    rv_pipelined_shift_unit #(.XLEN(32), .STAGES(2), .TAG_W(5)) u32 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bus(if32.slave)
    );
    rv_pipelined_shift_unit #(.XLEN(64), .STAGES(3), .TAG_W(5)) u64 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bus(if64.slave)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitors: compare the queue head on every valid cycle (so a stalled
    // output must hold steady) and retire it when the consumer is ready.
    always @(negedge clk) begin
        if (rst_n) begin
            check("in_ready32", 64'(if32.in_ready),
                  64'(!flush && (q32.size() < 2 || if32.out_ready)));
            if (if32.out_valid) begin
                if (q32.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL out32_unexpected: got tag %0d rd %h, expected no output",
                             if32.out_tag, if32.out_rd);
                end else begin
                    check("rd32", 64'(if32.out_rd), q32[0].rd);
                    check("tag32", 64'(if32.out_tag), 64'(q32[0].tag));
                    if (if32.out_ready) begin
                        $display("[%0t] dut32 out tag=%0d rd=%h", $time, if32.out_tag, if32.out_rd);
                        void'(q32.pop_front());
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("in_ready64", 64'(if64.in_ready),
                  64'(!flush && (q64.size() < 3 || if64.out_ready)));
            if (if64.out_valid) begin
                if (q64.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL out64_unexpected: got tag %0d rd %h, expected no output",
                             if64.out_tag, if64.out_rd);
                end else begin
                    check("rd64", if64.out_rd, q64[0].rd);
                    check("tag64", 64'(if64.out_tag), 64'(q64[0].tag));
                    if (if64.out_ready) begin
                        $display("[%0t] dut64 out tag=%0d rd=%h", $time, if64.out_tag, if64.out_rd);
                        void'(q64.pop_front());
                    end
                end
            end
        end
    end

    task automatic issue32(input logic [2:0] op, input logic word, input logic imm,
                           input logic [5:0] sh, input logic [31:0] rs1, input logic [31:0] rs2,
                           input logic [4:0] tag, input logic [31:0] exp);
        bit done = 0;
        if32.in_valid = 1'b1; if32.in_op = op; if32.in_word = word; if32.in_imm = imm;
        if32.in_instr = {6'h2A, sh, 20'hABCDE}; if32.in_rs1 = rs1; if32.in_rs2 = rs2;
        if32.in_tag = tag;
        for (int k = 0; k < 64 && !done; k++) begin
            @(negedge clk);
            if (if32.in_ready) begin
                @(posedge clk);
                q32.push_back('{tag: tag, rd: 64'(exp)});
                done = 1;
            end else begin
                @(posedge clk);
            end
        end
        #1 if32.in_valid = 1'b0;
        if (!done) begin
            n_cmp++; n_bad++;
            $display("FAIL issue32_timeout: tag %0d not accepted, expected acceptance", tag);
        end
    endtask

    task automatic issue64(input logic [2:0] op, input logic word, input logic imm,
                           input logic [5:0] sh, input logic [63:0] rs1, input logic [63:0] rs2,
                           input logic [4:0] tag, input logic [63:0] exp);
        bit done = 0;
        if64.in_valid = 1'b1; if64.in_op = op; if64.in_word = word; if64.in_imm = imm;
        if64.in_instr = {6'h15, sh, 20'h12345}; if64.in_rs1 = rs1; if64.in_rs2 = rs2;
        if64.in_tag = tag;
        for (int k = 0; k < 64 && !done; k++) begin
            @(negedge clk);
            if (if64.in_ready) begin
                @(posedge clk);
                q64.push_back('{tag: tag, rd: exp});
                done = 1;
            end else begin
                @(posedge clk);
            end
        end
        #1 if64.in_valid = 1'b0;
        if (!done) begin
            n_cmp++; n_bad++;
            $display("FAIL issue64_timeout: tag %0d not accepted, expected acceptance", tag);
        end
    endtask

    task automatic drain(input bit is64);
        bit empty = 0;
        for (int k = 0; k < 100 && !empty; k++) begin
            @(negedge clk);
            empty = is64 ? (q64.size() == 0) : (q32.size() == 0);
        end
        @(posedge clk); #1;
        if (!empty) begin
            n_cmp++; n_bad++;
            $display("FAIL drain_timeout: results still pending, expected none (dut%0d)",
                     is64 ? 64 : 32);
        end
    endtask

    // Counts the accepting edge as 1; the first negedge with out_valid high
    // ends the count.
    task automatic latency(input bit is64, input int exp_lat);
        int n = 1;
        bit seen = 0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            seen = is64 ? if64.out_valid : if32.out_valid;
            if (!seen) begin
                @(posedge clk);
                n++;
            end
        end
        check(is64 ? "latency64" : "latency32", 64'(n), 64'(exp_lat));
    endtask

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] rs1;
        logic [5:0]  sh;
        logic [31:0] exp;
    } vec32_t;

    vec32_t stream [0:7];

    initial begin
        stream[0] = '{3'd0, 32'h0000_0001, 6'd31, 32'h8000_0000};
        stream[1] = '{3'd1, 32'h8000_0000, 6'd31, 32'h0000_0001};
        stream[2] = '{3'd2, 32'h8000_0000, 6'd31, 32'hFFFF_FFFF};
        stream[3] = '{3'd3, 32'h8000_0001, 6'd1,  32'h0000_0003};
        stream[4] = '{3'd4, 32'h0000_0003, 6'd1,  32'h8000_0001};
        stream[5] = '{3'd2, 32'h7FFF_FFFF, 6'd30, 32'h0000_0001};
        stream[6] = '{3'd3, 32'hF000_0000, 6'd4,  32'h0000_000F};
        stream[7] = '{3'd7, 32'hDEAD_BEEF, 6'd3,  32'h0000_0000};

        rst_n = 1'b0; flush = 1'b0;
        if32.in_valid = 1'b0; if32.in_op = '0; if32.in_word = 1'b0; if32.in_imm = 1'b0;
        if32.in_instr = '0; if32.in_rs1 = '0; if32.in_rs2 = '0; if32.in_tag = '0;
        if32.out_ready = 1'b1;
        if64.in_valid = 1'b0; if64.in_op = '0; if64.in_word = 1'b0; if64.in_imm = 1'b0;
        if64.in_instr = '0; if64.in_rs1 = '0; if64.in_rs2 = '0; if64.in_tag = '0;
        if64.out_ready = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid32", 64'(if32.out_valid), 64'd0);
        check("rst_out_rd32", 64'(if32.out_rd), 64'd0);
        check("rst_out_tag32", 64'(if32.out_tag), 64'd0);
        check("rst_out_valid64", 64'(if64.out_valid), 64'd0);
        check("rst_out_rd64", if64.out_rd, 64'd0);
        check("rst_out_tag64", 64'(if64.out_tag), 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // XLEN=32 directed
        issue32(3'd2, 1'b0, 1'b0, 6'd0, 32'h8000_00F0, 32'd4, 5'd1, 32'hF800_000F);
        latency(1'b0, 2);
        drain(1'b0);
        issue32(3'd1, 1'b0, 1'b0, 6'd0, 32'h8000_00F0, 32'd4,    5'd2,  32'h0800_000F);
        issue32(3'd2, 1'b0, 1'b0, 6'd0, 32'h8000_00F0, 32'h24,   5'd3,  32'hF800_000F);
        issue32(3'd1, 1'b0, 1'b0, 6'd0, 32'h8000_00F0, 32'h24,   5'd4,  32'h0800_000F);
        issue32(3'd4, 1'b0, 1'b1, 6'd8, 32'h1234_5678, 32'h1F,   5'd5,  32'h7812_3456);
        issue32(3'd3, 1'b0, 1'b0, 6'd0, 32'h1234_5678, 32'h20,   5'd6,  32'h1234_5678);
        issue32(3'd0, 1'b1, 1'b0, 6'd0, 32'hFFFF_FFFF, 32'd4,    5'd7,  32'hFFFF_FFF0);
        issue32(3'd5, 1'b0, 1'b0, 6'd0, 32'hFFFF_FFFF, 32'd9,    5'd30, 32'h0000_0000);
        drain(1'b0);

        // XLEN=64 directed
        issue64(3'd0, 1'b1, 1'b0, 6'd0, 64'h0000_0000_4000_0001, 64'd1, 5'd3,
                64'hFFFF_FFFF_8000_0002);
        latency(1'b1, 3);
        drain(1'b1);
        issue64(3'd6, 1'b0, 1'b0, 6'd0, 64'h123, 64'd5, 5'd9, 64'h0);
        issue64(3'd2, 1'b0, 1'b0, 6'd0, 64'h8000_0000_0000_0000, 64'd63, 5'd10,
                64'hFFFF_FFFF_FFFF_FFFF);
        issue64(3'd2, 1'b1, 1'b0, 6'd0, 64'h0000_0000_8000_0000, 64'd4, 5'd11,
                64'hFFFF_FFFF_F800_0000);
        issue64(3'd4, 1'b1, 1'b0, 6'd0, 64'h1, 64'd1, 5'd12, 64'hFFFF_FFFF_8000_0000);
        issue64(3'd3, 1'b1, 1'b1, 6'd31, 64'hFFFF_FFFF_0000_0001, 64'd0, 5'd13,
                64'hFFFF_FFFF_8000_0000);
        issue64(3'd1, 1'b1, 1'b0, 6'd0, 64'h0000_0000_8000_0000, 64'h3F, 5'd14, 64'h1);
        issue64(3'd0, 1'b0, 1'b0, 6'd0, 64'h1, 64'h60, 5'd15, 64'h1_0000_0000);
        issue64(3'd3, 1'b0, 1'b0, 6'd0, 64'h8000_0000_0000_0001, 64'd1, 5'd16, 64'h3);
        issue64(3'd4, 1'b0, 1'b1, 6'd4, 64'hFF, 64'd0, 5'd17, 64'hF000_0000_0000_000F);
        issue64(3'd1, 1'b0, 1'b0, 6'd0, 64'hF000_0000_0000_0000, 64'd60, 5'd18, 64'hF);
        drain(1'b1);

        // Back-to-back stream with out_ready 1,0,0,1,0,0,...
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    issue32(stream[i].op, 1'b0, 1'b0, 6'd0, stream[i].rs1,
                            32'(stream[i].sh), 5'(16 + i), stream[i].exp);
                end
            end
            begin
                for (int c = 0; c < 60; c++) begin
                    if32.out_ready = (c % 3 == 0);
                    @(posedge clk); #1;
                end
                if32.out_ready = 1'b1;
            end
        join
        drain(1'b0);

        // Flush with two ops in flight and a third offered
        if32.out_ready = 1'b0;
        issue32(3'd0, 1'b0, 1'b0, 6'd0, 32'h1, 32'd1, 5'd24, 32'h2);
        issue32(3'd0, 1'b0, 1'b0, 6'd0, 32'h1, 32'd2, 5'd25, 32'h4);
        if32.in_valid = 1'b1; if32.in_tag = 5'd26; flush = 1'b1;
        @(negedge clk);
        check("flush_in_ready32", 64'(if32.in_ready), 64'd0);
        @(posedge clk);
        q32.delete();
        #1 flush = 1'b0; if32.in_valid = 1'b0; if32.out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("flush_out_valid32", 64'(if32.out_valid), 64'd0);
            @(posedge clk); #1;
        end

        // Reset in the middle of a stream
        issue32(3'd1, 1'b0, 1'b0, 6'd0, 32'h100, 32'd4, 5'd27, 32'h10);
        issue32(3'd1, 1'b0, 1'b0, 6'd0, 32'h200, 32'd4, 5'd28, 32'h20);
        rst_n = 1'b0;
        @(posedge clk);
        q32.delete(); q64.delete();
        @(negedge clk);
        check("midrst_out_valid32", 64'(if32.out_valid), 64'd0);
        check("midrst_out_rd32", 64'(if32.out_rd), 64'd0);
        check("midrst_out_tag32", 64'(if32.out_tag), 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready32", 64'(if32.in_ready), 64'd1);
        @(posedge clk); #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
